riscv_hazard_unit: RTL
======================

# riscv_hazard_unit

Pipeline hazard controller for the RISC-V core. It generates the stall and flush controls that the IF/ID and ID/EX pipeline registers consume, and decides when those registers hold, bubble or squash. It detects load-use hazards between the instruction in ID/EX and the instruction in decode, freezes the pipe while a MEM-stage bus access is outstanding, and sequences multi-cycle squashes after a taken branch or jump resolves in EX. It also keeps stall and flush performance counters.

## Interface
Parameters:
- DATA_WIDTH, 64: PC/target width.
- FETCH_LAT, 1: extra cycles of wrong-path fetch to squash after a redirect (0..7).
- LOAD_LAT, 1: bubble cycles inserted per load-use hazard (1..7).

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  core run enable; 0 freezes the pipe.
- i_id_rs1_addr, i_id_rs2_addr  in  5 each  source registers of the instruction in decode.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  decode instruction actually reads that source.
- i_ex_valid_instr, i_ex_read  in  1 each  ID/EX register holds a valid instruction / a load.
- i_ex_rd_addr  in  5  ID/EX destination register.
- i_ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- i_ex_target  in  DATA_WIDTH  redirect target PC.
- i_mem_req, i_mem_ready  in  1 each  MEM-stage bus request active / response accepted.
- o_stall_if  out  1  hold PC and IF/ID.
- o_stall  out  1  hold ID/EX (drives the ID/EX stall input).
- o_flush_if, o_flush_id  out  1 each  squash control fields entering ID/EX.
- o_pc_redirect  out  1  load PC from o_pc_target.
- o_pc_target  out  DATA_WIDTH  redirect PC.
- o_stall_cycles, o_flush_count  out  32 each  performance counters.

## Operation
- FSM states: RUN, LOAD_USE, REDIRECT. A 3-bit down-counter cnt sets state length.
- mem_wait = i_mem_req && !i_mem_ready. It has top priority in every state:
  - o_stall_if=o_stall=1, all flushes 0, o_pc_redirect=0.
  - FSM state and cnt are frozen.
- enable=0 behaves as mem_wait: full hold, no counter increments.
- RUN, redirect. Condition: i_ex_redirect. Response:
  - o_pc_redirect=1, o_pc_target=i_ex_target, o_flush_if=o_flush_id=1.
  - If FETCH_LAT>0: next state REDIRECT with cnt=FETCH_LAT. Otherwise stay in RUN.
- RUN, load-use. Condition: i_ex_valid_instr && i_ex_read && i_ex_rd_addr!=0 && ((uses_rs1 && rd==rs1) || (uses_rs2 && rd==rs2)). Response:
  - o_stall_if=1, o_flush_id=1, o_stall=0 (bubble into ID/EX).
  - If LOAD_LAT>1: next state LOAD_USE with cnt=LOAD_LAT-1. Otherwise stay in RUN.
- Redirect and load-use in the same cycle: redirect wins, no bubble.
- REDIRECT: o_flush_if=1; load-use checks ignored. cnt decrements; at cnt==1, next state RUN.
- LOAD_USE: o_stall_if=1, o_flush_id=1. A new i_ex_redirect preempts: it is handled exactly as a redirect in RUN. Otherwise cnt decrements; at cnt==1, next state RUN.
- x0 as destination never causes a hazard.
- o_stall_cycles increments every cycle with o_stall_if=1 while not in reset.
- o_flush_count increments once per accepted redirect.
- Both counters wrap from 0xFFFF_FFFF to 0.

## Timing
- All hazard outputs are combinational from inputs and state, in the same cycle. There is zero-cycle latency to the pipeline registers.
- o_pc_target is a pass-through of i_ex_target, qualified by o_pc_redirect.
- Reset asserted: state RUN, cnt 0, both counters 0. All outputs forced to 0, including o_pc_target.
- Reset mid-REDIRECT or mid-LOAD_USE aborts immediately. The first cycle after reset is in RUN.
- A redirect held during mem_wait stays pending, because EX is frozen. It is acted on in the first cycle with i_mem_ready=1 or i_mem_req=0.
- With i_mem_req && i_mem_ready in the same cycle there is no stall.

## Structure
- riscv_pkg gains the hazard state enum hz_state_t (RUN, LOAD_USE, REDIRECT).
- riscv_pkg gains the constant REG_ZERO = 5'd0.
- One natural sub-module, riscv_hazard_cmp: the combinational load-use compare (rd vs rs1/rs2 with use qualifiers). Everything else stays in riscv_hazard_unit.

## Test plan
- Load-use, LOAD_LAT=1: i_ex_read=1, rd=5, rs1=5, uses_rs1=1 -> exactly 1 cycle of o_stall_if=1, o_flush_id=1, o_stall=0; o_stall_cycles=1.
- Load-use on x0: rd=0, rs1=0 -> no stall. Same hazard with uses_rs1=0 -> no stall.
- Redirect, FETCH_LAT=2, target 0x8000_0040:
  - First cycle: o_pc_redirect=1 with target 0x8000_0040, both flushes 1.
  - Next 2 cycles: o_flush_if=1 only.
  - o_flush_count=1.
- mem_wait for 3 cycles during REDIRECT with cnt=2: full stall for 3 cycles, then 2 remaining flush_if cycles; o_stall_cycles=3.
- Redirect and load-use in the same cycle: redirect response, no bubble. Preset o_stall_cycles=0xFFFF_FFFF, then one stall cycle -> wraps to 0.
- Reset pulse in mid LOAD_USE (LOAD_LAT=4): all outputs 0 while reset is high; the following cycle is RUN with no stall.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: hazard FSM encoding, hazard control bundle, architectural constants.
// Pure declarations; no logic, no latency.
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LOAD_USE = 2'd1,
      REDIRECT = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic stall_if;
      logic stall;
      logic flush_if;
      logic flush_id;
      logic pc_redirect;
   } hz_ctl_t;

endpackage

// File: rtl/riscv_hazard_cmp.sv
// Load-use compare: the load in ID/EX writes a register that decode actually reads.
// Purely combinational, zero latency, no backpressure.
module riscv_hazard_cmp
   import riscv_pkg::*;
(
   input  logic       ex_valid_i,
   input  logic       ex_read_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic       uses_rs1_i,
   input  logic       uses_rs2_i,
   output logic       hazard_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = uses_rs1_i && (ex_rd_i == rs1_i);
   assign rs2_hit  = uses_rs2_i && (ex_rd_i == rs2_i);
   // x0 is hardwired to zero, so a load targeting it never produces a dependency.
   assign hazard_o = ex_valid_i && ex_read_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, MEM-wait freeze, redirect squash sequencing, perf counters.
// Controls are combinational from inputs and state (zero latency); a MEM wait or enable=0 holds the whole pipe.
module riscv_hazard_unit
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int FETCH_LAT  = 1,
   parameter int LOAD_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [4:0]            i_id_rs1_addr,
   input  logic [4:0]            i_id_rs2_addr,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   input  logic                  i_ex_valid_instr,
   input  logic                  i_ex_read,
   input  logic [4:0]            i_ex_rd_addr,
   input  logic                  i_ex_redirect,
   input  logic [DATA_WIDTH-1:0] i_ex_target,
   input  logic                  i_mem_req,
   input  logic                  i_mem_ready,
   output logic                  o_stall_if,
   output logic                  o_stall,
   output logic                  o_flush_if,
   output logic                  o_flush_id,
   output logic                  o_pc_redirect,
   output logic [DATA_WIDTH-1:0] o_pc_target,
   output logic [31:0]           o_stall_cycles,
   output logic [31:0]           o_flush_count
);

   localparam logic [2:0] FETCH_CNT = 3'(FETCH_LAT);
   localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LAT - 1);

   hz_state_t   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;
   hz_ctl_t     ctl;
   logic        hazard;
   logic        hold;

   riscv_hazard_cmp u_cmp (
      .ex_valid_i (i_ex_valid_instr),
      .ex_read_i  (i_ex_read),
      .ex_rd_i    (i_ex_rd_addr),
      .rs1_i      (i_id_rs1_addr),
      .rs2_i      (i_id_rs2_addr),
      .uses_rs1_i (i_id_uses_rs1),
      .uses_rs2_i (i_id_uses_rs2),
      .hazard_o   (hazard)
   );

   assign hold = !enable || (i_mem_req && !i_mem_ready);

   always_comb begin
      ctl     = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (hold) begin
         // EX is frozen, so a redirect seen now stays pending and is taken once the hold clears.
         ctl.stall_if = 1'b1;
         ctl.stall    = 1'b1;
      end else begin
         case (state_q)
            RUN, LOAD_USE: begin
               if (i_ex_redirect) begin
                  ctl.flush_if    = 1'b1;
                  ctl.flush_id    = 1'b1;
                  ctl.pc_redirect = 1'b1;
                  if (FETCH_LAT > 0) begin
                     state_d = REDIRECT;
                     cnt_d   = FETCH_CNT;
                  end else begin
                     state_d = RUN;
                     cnt_d   = 3'd0;
                  end
               end else if (state_q == LOAD_USE) begin
                  ctl.stall_if = 1'b1;
                  ctl.flush_id = 1'b1;
                  cnt_d        = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                  if (cnt_q <= 3'd1) state_d = RUN;
               end else if (hazard) begin
                  ctl.stall_if = 1'b1;
                  ctl.flush_id = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = LOAD_USE;
                     cnt_d   = LOAD_CNT;
                  end
               end
            end
            REDIRECT: begin
               ctl.flush_if = 1'b1;
               cnt_d        = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
               if (cnt_q <= 3'd1) state_d = RUN;
            end
            default: begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // Disabled cycles are a full hold but are not counted as hazard stalls.
   assign stall_cycles_d = (ctl.stall_if && enable) ? stall_cycles_q + 32'd1 : stall_cycles_q;
   assign flush_count_d  = ctl.pc_redirect ? flush_count_q + 32'd1 : flush_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         cnt_q          <= 3'd0;
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign o_stall_if     = !reset && ctl.stall_if;
   assign o_stall        = !reset && ctl.stall;
   assign o_flush_if     = !reset && ctl.flush_if;
   assign o_flush_id     = !reset && ctl.flush_id;
   assign o_pc_redirect  = !reset && ctl.pc_redirect;
   assign o_pc_target    = o_pc_redirect ? i_ex_target : '0;
   assign o_stall_cycles = stall_cycles_q;
   assign o_flush_count  = flush_count_q;

endmodule
